max_pooling_controller: RTL and testbench

Sequences one pooling job through the Max_Pooling datapath. Latches a job configuration on a start handshake and clears the pooling datapath. Streams input columns from the upstream systolic-array drain using a valid/ready handshake and drives Max_Pooling's EN, SYNC_RST and configuration inputs. Tags pooled output columns with valid/last markers and signals job completion.

---
 rtl/max_pooling_controller.sv | 143 ++++++++++++++
 tb/tb_max_pooling_controller.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/max_pooling_controller.sv
// Job sequencer for the Max_Pooling datapath: latches a configuration on Start,
// clears the pool, streams input columns and tags pooled columns with valid/last.
module max_pooling_controller #(
  parameter int SA_LENGTH       = 10,
  parameter int MAX_FILTER_SIZE = 7,
  parameter int POOL_LATENCY    = 1
) (
  input  logic                         CLK,
  input  logic                         ASYNC_RST,
  input  logic                         Start,
  input  logic [$clog2(SA_LENGTH):0]   CfgHeight,
  input  logic [$clog2(SA_LENGTH):0]   CfgWidth,
  input  logic [2:0]                   CfgFilterSize,
  output logic                         Busy,
  output logic                         Done,
  output logic                         CfgError,
  input  logic                         InValid,
  output logic                         InReady,
  output logic                         PoolEn,
  output logic                         PoolSyncRst,
  output logic [$clog2(SA_LENGTH)-1:0] PoolImageHeight,
  output logic [$clog2(SA_LENGTH)-1:0] PoolImageWidth,
  output logic [2:0]                   PoolFilterSize,
  output logic                         OutValid,
  output logic                         OutLast
);

  localparam int HW = $clog2(SA_LENGTH) + 1;
  localparam int PW = $clog2(SA_LENGTH);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    STREAM,
    DRAIN,
    DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [PW-1:0]           height_q;
  logic [HW-1:0]           width_q;
  logic [2:0]              filt_q;
  logic [HW-1:0]           col_q;
  logic [2:0]              win_q;
  logic [2:0]              drain_q;
  logic                    cfg_err_q;
  logic [POOL_LATENCY-1:0] mark_v_q;
  logic [POOL_LATENCY-1:0] mark_l_q;

  logic          cfg_legal;
  logic [HW-1:0] filt_ext;
  logic          start_ok;
  logic          start_bad;
  logic          accept;
  logic          col_last;
  logic          close;

  assign filt_ext  = HW'(CfgFilterSize);
  assign cfg_legal = (CfgWidth != '0) && (CfgWidth <= HW'(SA_LENGTH)) &&
                     (CfgHeight != '0) && (CfgHeight <= HW'(SA_LENGTH)) &&
                     (CfgFilterSize != 3'd0) &&
                     (CfgFilterSize <= 3'(MAX_FILTER_SIZE)) &&
                     (filt_ext <= CfgWidth);

  // Gated by the reset level so Busy stays low while reset is held.
  assign start_ok  = ASYNC_RST && (state_q == IDLE) && Start && cfg_legal;
  assign start_bad = (state_q == IDLE) && Start && !cfg_legal;

  assign accept   = (state_q == STREAM) && InValid;
  assign col_last = (col_q == width_q - HW'(1));
  assign close    = (win_q == filt_q - 3'd1) || col_last;

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_ok) state_d = CLEAR;
      CLEAR:   state_d = STREAM;
      STREAM:  if (accept && col_last) state_d = DRAIN;
      DRAIN:   if (drain_q == 3'(POOL_LATENCY - 1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers
  // sample the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge ASYNC_RST) begin
    if (!ASYNC_RST) begin
      state_q   <= IDLE;
      height_q  <= '0;
      width_q   <= '0;
      filt_q    <= '0;
      col_q     <= '0;
      win_q     <= '0;
      drain_q   <= '0;
      cfg_err_q <= 1'b0;
      mark_v_q  <= '0;
      mark_l_q  <= '0;
    end else begin
      state_q   <= state_d;
      cfg_err_q <= start_bad;

      if (start_ok) begin
        height_q <= CfgHeight[PW-1:0];
        width_q  <= CfgWidth;
        filt_q   <= CfgFilterSize;
      end

      if (state_q == CLEAR) begin
        col_q <= '0;
        win_q <= '0;
      end else if (accept) begin
        col_q <= col_q + HW'(1);
        win_q <= close ? 3'd0 : win_q + 3'd1;
      end

      drain_q <= (state_q == DRAIN) ? drain_q + 3'd1 : 3'd0;

      // Marker line runs free so the pool's fixed latency is matched on every cycle.
      mark_v_q[0] <= accept && close;
      mark_l_q[0] <= accept && close && col_last;
      for (int i = 1; i < POOL_LATENCY; i++) begin
        mark_v_q[i] <= mark_v_q[i-1];
        mark_l_q[i] <= mark_l_q[i-1];
      end
    end
  end

  assign Busy            = start_ok || (state_q == CLEAR) || (state_q == STREAM) ||
                           (state_q == DRAIN);
  assign Done            = (state_q == DONE);
  assign CfgError        = cfg_err_q;
  assign InReady         = (state_q == STREAM);
  assign PoolEn          = accept;
  assign PoolSyncRst     = (state_q == CLEAR);
  assign PoolImageHeight = height_q;
  assign PoolImageWidth  = width_q[PW-1:0];
  assign PoolFilterSize  = filt_q;
  assign OutValid        = mark_v_q[POOL_LATENCY-1];
  assign OutLast         = mark_l_q[POOL_LATENCY-1];

endmodule

// File: tb/tb_max_pooling_controller.sv
// Directed bench for max_pooling_controller; pooled-column markers are scored
// against a queue of expected (cycle, last) entries built while driving columns.
module tb_max_pooling_controller;

  localparam int SA  = 10;
  localparam int MF  = 7;
  localparam int LAT = 2;
  localparam int HW  = $clog2(SA) + 1;
  localparam int PW  = $clog2(SA);

  logic          CLK = 1'b0;
  logic          ASYNC_RST = 1'b1;
  logic          Start = 1'b0;
  logic [HW-1:0] CfgHeight = '0;
  logic [HW-1:0] CfgWidth = '0;
  logic [2:0]    CfgFilterSize = '0;
  logic          InValid = 1'b0;
  logic          Busy, Done, CfgError, InReady, PoolEn, PoolSyncRst;
  logic [PW-1:0] PoolImageHeight, PoolImageWidth;
  logic [2:0]    PoolFilterSize;
  logic          OutValid, OutLast;

  max_pooling_controller #(
    .SA_LENGTH      (SA),
    .MAX_FILTER_SIZE(MF),
    .POOL_LATENCY   (LAT)
  ) dut (
    .CLK            (CLK),
    .ASYNC_RST      (ASYNC_RST),
    .Start          (Start),
    .CfgHeight      (CfgHeight),
    .CfgWidth       (CfgWidth),
    .CfgFilterSize  (CfgFilterSize),
    .Busy           (Busy),
    .Done           (Done),
    .CfgError       (CfgError),
    .InValid        (InValid),
    .InReady        (InReady),
    .PoolEn         (PoolEn),
    .PoolSyncRst    (PoolSyncRst),
    .PoolImageHeight(PoolImageHeight),
    .PoolImageWidth (PoolImageWidth),
    .PoolFilterSize (PoolFilterSize),
    .OutValid       (OutValid),
    .OutLast        (OutLast)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int   due;
    logic last;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;
  int   ov_cnt = 0;
  int   ol_cnt = 0;

  logic [PW-1:0] exp_ph = '0;
  logic [PW-1:0] exp_pw = '0;
  logic [2:0]    exp_pf = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every pooled column must match the oldest expected marker.
  always @(negedge CLK) begin
    if (ASYNC_RST && OutValid) begin
      ov_cnt++;
      if (OutLast) ol_cnt++;
      if (sb.size() == 0) begin
        check("unexpected_outvalid", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("outvalid_cycle", cyc, mon_e.due);
        check("outlast", OutLast, mon_e.last);
      end
    end else if (!OutValid) begin
      check("outlast_without_valid", OutLast, 1'b0);
    end
  end

  task automatic check_pool_cfg(input string tag);
    check({tag, "_ph"}, PoolImageHeight, exp_ph);
    check({tag, "_pw"}, PoolImageWidth, exp_pw);
    check({tag, "_pf"}, PoolFilterSize, exp_pf);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, Busy, 1'b0);
    check({tag, "_done"}, Done, 1'b0);
    check({tag, "_cfgerr"}, CfgError, 1'b0);
    check({tag, "_ready"}, InReady, 1'b0);
    check({tag, "_en"}, PoolEn, 1'b0);
    check({tag, "_syncrst"}, PoolSyncRst, 1'b0);
    check({tag, "_ov"}, OutValid, 1'b0);
    check({tag, "_ol"}, OutLast, 1'b0);
    check_pool_cfg(tag);
  endtask

  task automatic run_job(input int w, input int h, input int f, input bit gap,
                         input int glitch_at, input int abort_after);
    int busy_n = 0, acc = 0, win = 0, si = 0, last_acc = 0;
    bit close, done_seen = 0;
    ov_cnt = 0;
    ol_cnt = 0;

    @(posedge CLK); #1;
    Start = 1'b1; CfgWidth = HW'(w); CfgHeight = HW'(h); CfgFilterSize = 3'(f);
    @(negedge CLK);
    check("start_busy", Busy, 1'b1);
    check("start_syncrst", PoolSyncRst, 1'b0);
    check("start_done_low", Done, 1'b0);
    check_pool_cfg("start_held");
    busy_n++;

    @(posedge CLK); #1;
    Start = 1'b0;
    exp_ph = h[PW-1:0]; exp_pw = w[PW-1:0]; exp_pf = f[2:0];
    @(negedge CLK);
    check("clear_syncrst", PoolSyncRst, 1'b1);
    check("clear_en", PoolEn, 1'b0);
    check("clear_ready", InReady, 1'b0);
    check("clear_busy", Busy, 1'b1);
    check_pool_cfg("clear");
    busy_n++;

    while (acc < w && si < 100) begin
      @(posedge CLK); #1;
      InValid = gap ? (si % 2 == 0) : 1'b1;
      if (si == glitch_at) begin
        Start = 1'b1; CfgWidth = HW'(3); CfgFilterSize = 3'd1;
      end else begin
        Start = 1'b0;
      end
      @(negedge CLK);
      check("stream_ready", InReady, 1'b1);
      check("stream_en", PoolEn, InValid);
      check("stream_busy", Busy, 1'b1);
      check("stream_syncrst", PoolSyncRst, 1'b0);
      check("stream_cfgerr", CfgError, 1'b0);
      busy_n++;
      if (InValid) begin
        acc++;
        close = (win == f - 1) || (acc == w);
        if (close) sb.push_back('{due: cyc + LAT, last: (acc == w)});
        win = close ? 0 : win + 1;
        last_acc = cyc;
      end
      si++;
      if (abort_after != 0 && acc == abort_after) begin
        @(posedge CLK); #1;
        InValid = 1'b0;
        Start = 1'b0;
        ASYNC_RST = 1'b0;
        sb.delete();
        exp_ph = '0; exp_pw = '0; exp_pf = '0;
        #1;
        check_all_zero("abort");
        repeat (3) begin
          @(negedge CLK);
          check("abort_no_done", Done, 1'b0);
          check("abort_no_ov", OutValid, 1'b0);
        end
        @(posedge CLK); #1;
        ASYNC_RST = 1'b1;
        return;
      end
    end

    @(posedge CLK); #1;
    Start = 1'b0;
    InValid = 1'b1;
    for (int k = 0; k < 20 && !done_seen; k++) begin
      @(negedge CLK);
      if (Done) begin
        done_seen = 1;
      end else begin
        check("drain_ready", InReady, 1'b0);
        check("drain_en", PoolEn, 1'b0);
        if (Busy) busy_n++;
      end
    end
    check("done_seen", done_seen, 1'b1);
    check("done_cycle", cyc, last_acc + LAT + 1);
    check("done_busy_low", Busy, 1'b0);
    check("busy_length", busy_n, 2 + si + LAT);
    check("sb_empty", sb.size(), 0);
    check("ov_count", ov_cnt, (w + f - 1) / f);
    check("ol_count", ol_cnt, 1);
    check_pool_cfg("done");
    InValid = 1'b0;
  endtask

  task automatic bad_start(input int w, input int h, input int f);
    @(posedge CLK); #1;
    Start = 1'b1; CfgWidth = HW'(w); CfgHeight = HW'(h); CfgFilterSize = 3'(f);
    @(negedge CLK);
    check("bad_start_busy", Busy, 1'b0);
    check("bad_start_syncrst", PoolSyncRst, 1'b0);
    @(posedge CLK); #1;
    Start = 1'b0;
    @(negedge CLK);
    check("bad_cfgerr_pulse", CfgError, 1'b1);
    check("bad_busy", Busy, 1'b0);
    check("bad_syncrst", PoolSyncRst, 1'b0);
    check("bad_ready", InReady, 1'b0);
    @(negedge CLK);
    check("bad_cfgerr_end", CfgError, 1'b0);
    check("bad_busy_after", Busy, 1'b0);
    check("bad_syncrst_after", PoolSyncRst, 1'b0);
    check_pool_cfg("bad_held");
  endtask

  initial begin
    #2 ASYNC_RST = 1'b0;
    #1 check_all_zero("reset");
    repeat (2) @(negedge CLK);
    check_all_zero("reset_hold");
    @(posedge CLK); #1;
    ASYNC_RST = 1'b1;

    run_job(10, 10, 4, 1'b0, -1, 0);
    run_job(4, 5, 3, 1'b0, -1, 0);
    run_job(6, 5, 3, 1'b0, -1, 0);
    run_job(10, 10, 4, 1'b1, -1, 0);
    bad_start(10, 10, 0);
    bad_start(4, 4, 5);
    bad_start(11, 10, 3);
    run_job(10, 10, 4, 1'b0, 3, 0);
    run_job(10, 10, 4, 1'b0, -1, 5);
    run_job(10, 10, 4, 1'b0, -1, 0);

    repeat (2) @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
